// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data width, canonical NOP and the
// fetch-stage state encoding. The FAULT state exists only when
// STAGE_IF_MISALIGN_CHECK_EN is defined.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    RST_WAIT,
    FETCH,
    HOLD,
    DRAIN
`ifdef STAGE_IF_MISALIGN_CHECK_EN
    , FAULT
`endif
  } fetch_state_t;

endpackage

// File: rtl/stage_if_skid_buf.sv
// One-entry skid buffer holding a fetched word (and its PC) that arrived
// while decode was stalled.
module if_skid_buf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] in_data,
  input  logic [XLEN-1:0] in_pc,
  output logic            valid,
  output logic [XLEN-1:0] data,
  output logic [XLEN-1:0] pc
);

  // Capture on load; drain or clear empties the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (clear || drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      pc    <= in_pc;
    end
  end

endmodule

// File: rtl/stage_if.sv
// Instruction fetch stage: drives a request/ack instruction memory port and
// the IF/ID pipeline register, with stall, redirect/flush and a one-entry
// skid buffer. Optional misaligned-redirect fault handling is enabled by
// defining STAGE_IF_MISALIGN_CHECK_EN.
module stage_if
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  pending_pc, pending_next;
  logic         valid_next;
  logic [31:0]  opc_next, instr_next;
  logic [31:0]  redir_tgt;
  logic         jump;
  logic [31:0]  jump_pc;
  logic         skid_load, skid_drain;
  logic         skid_valid;
  logic [31:0]  skid_data, skid_pc;

`ifdef STAGE_IF_MISALIGN_CHECK_EN
  logic fault_q, fault_next;
  assign redir_tgt = redirect_pc;
  assign if_fault  = fault_q;
`else
  assign redir_tgt = {redirect_pc[31:2], 2'b00};
  assign if_fault  = 1'b0;
`endif

  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = pc;

  if_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .drain   (skid_drain),
    .clear   (redirect_valid),
    .in_data (imem_rdata),
    .in_pc   (pc),
    .valid   (skid_valid),
    .data    (skid_data),
    .pc      (skid_pc)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_WAIT;
      pc         <= RESET_PC;
      pending_pc <= '0;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= NOP_INSTR;
`ifdef STAGE_IF_MISALIGN_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pending_pc <= pending_next;
      if_valid   <= valid_next;
      if_pc      <= opc_next;
      if_instr   <= instr_next;
`ifdef STAGE_IF_MISALIGN_CHECK_EN
      fault_q    <= fault_next;
`endif
    end
  end

  // Next-state and next-register logic. A redirect that can retarget the pc
  // immediately is funnelled through jump/jump_pc so the fault check lives
  // in one place.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending_pc;
    valid_next   = if_valid;
    opc_next     = if_pc;
    instr_next   = if_instr;
    skid_load    = 1'b0;
    skid_drain   = 1'b0;
    jump         = 1'b0;
    jump_pc      = pc;
`ifdef STAGE_IF_MISALIGN_CHECK_EN
    fault_next   = fault_q;
`endif
    case (state)
      RST_WAIT: begin
        if (redirect_valid) begin
          jump    = 1'b1;
          jump_pc = redir_tgt;
        end else begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            jump    = 1'b1;
            jump_pc = redir_tgt;
          end else begin
            pending_next = redir_tgt;
            state_next   = DRAIN;
          end
        end else if (stall) begin
          if (imem_ack) begin
            skid_load  = 1'b1;
            state_next = HOLD;
          end
        end else if (imem_ack) begin
          valid_next = 1'b1;
          opc_next   = pc;
          instr_next = imem_rdata;
          pc_next    = pc + 32'd4;
        end else begin
          valid_next = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          jump    = 1'b1;
          jump_pc = redir_tgt;
        end else if (!stall) begin
          valid_next = skid_valid;
          opc_next   = skid_pc;
          instr_next = skid_data;
          skid_drain = 1'b1;
          pc_next    = pc + 32'd4;
          state_next = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_valid) pending_next = redir_tgt;
        if (imem_ack) begin
          jump    = 1'b1;
          jump_pc = redirect_valid ? redir_tgt : pending_pc;
        end
      end
`ifdef STAGE_IF_MISALIGN_CHECK_EN
      FAULT: begin
        if (redirect_valid) begin
          jump    = 1'b1;
          jump_pc = redir_tgt;
        end
      end
`endif
      default: state_next = RST_WAIT;
    endcase

    if (redirect_valid) begin
      valid_next = 1'b0;
      instr_next = NOP_INSTR;
    end

    if (jump) begin
      pc_next    = jump_pc;
      state_next = FETCH;
`ifdef STAGE_IF_MISALIGN_CHECK_EN
      if (|jump_pc[1:0]) begin
        state_next = FAULT;
        fault_next = 1'b1;
      end else begin
        fault_next = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: directed scenarios plus a randomized run
// checked against a delivered-instruction-stream model.
module tb_stage_if;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_fault;
  logic        ack_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = mem_word(imem_addr);

  stage_if #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_fault       (if_fault)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ack);
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ack_en = ack;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    cyc(); cyc(); cyc();
    ack_en = 1'b0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_valid); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", if_pc); end
    total++; if (if_instr !== 32'h0000_0013) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", if_instr); end
    total++; if (if_fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", if_fault); end
    ack_en = 1'b1;
    cyc();
    rst_n = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rstwait_req got=%b exp=0", imem_req); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rstwait_valid got=%b exp=0", if_valid); end
  endtask

  task automatic test_sequential();
    do_reset(1'b1);
    cyc();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0)
      begin bad++; $display("FAIL seq_first req=%b addr=%h valid=%b exp 1/0/0", imem_req, imem_addr, if_valid); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (if_valid !== 1'b1 || if_pc !== 32'(i * 4))
        begin bad++; $display("FAIL seq_pc valid=%b got=%h exp=%h", if_valid, if_pc, 32'(i * 4)); end
      total++; if (if_instr !== mem_word(32'(i * 4)))
        begin bad++; $display("FAIL seq_instr got=%h exp=%h", if_instr, mem_word(32'(i * 4))); end
    end
  endtask

  task automatic test_stall();
    do_reset(1'b1);
    cyc(); cyc(); cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== mem_word(32'h4))
        begin bad++; $display("FAIL stall_hold valid=%b pc=%h instr=%h exp pc=4", if_valid, if_pc, if_instr); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_norefetch req=%b exp=0", imem_req); end
    end
    stall = 1'b0;
    cyc();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== mem_word(32'h8))
      begin bad++; $display("FAIL stall_release pc=%h instr=%h exp pc=8", if_pc, if_instr); end
    total++; if (imem_addr !== 32'hC || imem_req !== 1'b1)
      begin bad++; $display("FAIL stall_nextaddr got=%h req=%b exp=0000000c", imem_addr, imem_req); end
  endtask

  task automatic test_drain();
    do_reset(1'b0);
    cyc();
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0)
        begin bad++; $display("FAIL drain_hold req=%b addr=%h valid=%b exp 1/0/0", imem_req, imem_addr, if_valid); end
      cyc();
    end
    ack_en = 1'b1;
    #1;
    cyc();
    total++; if (if_valid !== 1'b0 || imem_addr !== 32'h100)
      begin bad++; $display("FAIL drain_drop valid=%b addr=%h exp 0/00000100", if_valid, imem_addr); end
    cyc();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== mem_word(32'h100))
      begin bad++; $display("FAIL drain_resume valid=%b pc=%h exp pc=00000100", if_valid, if_pc); end
  endtask

  task automatic test_redirect_stall();
    do_reset(1'b1);
    cyc(); cyc();
    stall = 1'b1;
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc();
    total++; if (if_valid !== 1'b0 || if_instr !== 32'h0000_0013)
      begin bad++; $display("FAIL rs_flush valid=%b instr=%h exp 0/00000013", if_valid, if_instr); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
      begin bad++; $display("FAIL rs_addr req=%b addr=%h exp 1/00000040", imem_req, imem_addr); end
    redirect_valid = 1'b0; stall = 1'b0;
    cyc();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== mem_word(32'h40))
      begin bad++; $display("FAIL rs_skidclr valid=%b pc=%h exp pc=00000040", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    cyc();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC)
      begin bad++; $display("FAIL wrap_pc valid=%b pc=%h exp fffffffc", if_valid, if_pc); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%h exp=0", imem_addr); end
    cyc();
    total++; if (if_pc !== 32'h0 || if_instr !== mem_word(32'h0))
      begin bad++; $display("FAIL wrap_zero pc=%h exp=0", if_pc); end
  endtask

`ifdef STAGE_IF_MISALIGN_CHECK_EN
  task automatic test_fault();
    do_reset(1'b1);
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (if_fault !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0)
        begin bad++; $display("FAIL fault_hold fault=%b req=%b valid=%b exp 1/0/0", if_fault, imem_req, if_valid); end
      cyc();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect_valid = 1'b0;
    total++; if (if_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
      begin bad++; $display("FAIL fault_exit fault=%b req=%b addr=%h exp 0/1/00000200", if_fault, imem_req, imem_addr); end
    cyc();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h200)
      begin bad++; $display("FAIL fault_resume valid=%b pc=%h exp 00000200", if_valid, if_pc); end
  endtask
`endif

  // Model: the decode side must see the instruction stream starting at the
  // reset PC, continuing sequentially, restarting at every redirect target;
  // stalls freeze the outputs, a redirect flushes to a NOP bubble, and a
  // pending memory request never changes address before its ack.
  task automatic test_random();
    logic [31:0] exp_next;
    logic        p_valid, p_req, p_ack;
    logic [31:0] p_pc, p_instr, p_addr, tgt;
    int          delivered;
    do_reset(1'b1);
    exp_next  = 32'h0;
    delivered = 0;
    for (int n = 0; n < 800; n++) begin
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
`ifdef STAGE_IF_MISALIGN_CHECK_EN
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
`else
      redirect_pc    = $urandom;
`endif
      ack_en         = ($urandom_range(0, 2) != 0);
      #1;
      p_valid = if_valid; p_pc = if_pc; p_instr = if_instr;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      tgt = {redirect_pc[31:2], 2'b00};
      cyc();
      if (redirect_valid) begin
        total++; if (if_valid !== 1'b0 || if_instr !== NOP_INSTR)
          begin bad++; $display("FAIL rnd_flush n=%0d valid=%b instr=%h exp 0/00000013", n, if_valid, if_instr); end
        exp_next = tgt;
      end else if (stall) begin
        total++; if (if_valid !== p_valid || if_pc !== p_pc || if_instr !== p_instr)
          begin bad++; $display("FAIL rnd_hold n=%0d pc=%h exp=%h valid=%b exp=%b", n, if_pc, p_pc, if_valid, p_valid); end
      end else if (if_valid) begin
        total++; if (if_pc !== exp_next || if_instr !== mem_word(exp_next))
          begin bad++; $display("FAIL rnd_stream n=%0d pc=%h exp=%h instr=%h", n, if_pc, exp_next, if_instr); end
        exp_next  = exp_next + 32'd4;
        delivered++;
      end
      if (p_req && !p_ack) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== p_addr)
          begin bad++; $display("FAIL rnd_reqstable n=%0d req=%b addr=%h exp 1/%h", n, imem_req, imem_addr, p_addr); end
      end
    end
    stall = 1'b0; redirect_valid = 1'b0;
    total++; if (delivered < 50)
      begin bad++; $display("FAIL rnd_progress delivered=%0d exp>=50", delivered); end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ack_en = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_drain();
    test_redirect_stall();
    test_wrap();
`ifdef STAGE_IF_MISALIGN_CHECK_EN
    test_fault();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_if.md
STAGE_IF -- requirements
Module: stage_if

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port stall  input  1  decode not ready; IF/ID outputs hold.
REQ-005 The block SHALL have port redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-006 The block SHALL have port redirect_pc  input  32  redirect target.
REQ-007 The block SHALL have port imem_req  output  1  fetch request.
REQ-008 The block SHALL have port imem_addr  output  32  fetch address.
REQ-009 The block SHALL have port imem_ack  input  1  read data valid this cycle.
REQ-010 The block SHALL have port imem_rdata  input  32  instruction word.
REQ-011 The block SHALL have port if_valid  output  1  IF/ID entry valid.
REQ-012 The block SHALL have port if_pc  output  32  PC of IF/ID instruction.
REQ-013 The block SHALL have port if_instr  output  32  instruction to decode.
REQ-014 The block SHALL have port if_fault  output  1  misaligned redirect fault, sticky.

Function
REQ-015 The FSM SHALL have states RST_WAIT, FETCH, HOLD, DRAIN, FAULT; imem_req SHALL be 1 only in FETCH and DRAIN; imem_addr SHALL equal the pc register.
REQ-016 Memory protocol: imem_req and imem_addr SHALL stay stable until imem_ack; ack completes the request in the same cycle, so zero-wait memory gives one instruction per cycle.
REQ-017 RST_WAIT SHALL last exactly one cycle after rst_n release, then go to FETCH; with zero-wait ack, if_valid=1 and if_pc=RESET_PC on the second rising edge after release.
REQ-018 FETCH with ack and !stall: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC).
REQ-019 FETCH with ack and stall: the word SHALL go into the one-entry skid buffer, outputs SHALL hold, and the FSM SHALL go to HOLD.
REQ-020 FETCH with !ack and !stall: if_valid<=0 (bubble).
REQ-021 FETCH with stall: outputs SHALL hold.
REQ-022 HOLD with !stall: buffer SHALL load into outputs, pc<=pc+4, FSM to FETCH.
REQ-023 HOLD with stall: everything SHALL hold.
REQ-024 redirect_valid SHALL have priority over stall and ack: if_valid<=0, if_instr<=NOP (32'h0000_0013), skid buffer SHALL be discarded.
REQ-025 Redirect in FETCH with ack, or in HOLD/RST_WAIT: pc<=redirect_pc, FSM to FETCH, and any same-cycle ack data SHALL be dropped.
REQ-026 Redirect in FETCH without ack: pending_pc<=redirect_pc, FSM to DRAIN.
REQ-027 DRAIN SHALL keep requesting the old address; on ack, data SHALL be dropped, pc<=pending_pc, FSM to FETCH; a new redirect in DRAIN SHALL overwrite pending_pc.
REQ-028 if_valid SHALL stay 0 throughout DRAIN.

Reset
REQ-029 rst_n low SHALL immediately force: pc=RESET_PC, pending_pc=0, state=RST_WAIT, imem_req=0, if_valid=0, if_pc=0, if_instr=32'h0000_0013, if_fault=0, skid buffer empty.
REQ-030 Reset mid-request SHALL abandon the request without waiting for ack; a later stray ack SHALL be ignored.

Configuration
REQ-031 With STAGE_IF_MISALIGN_CHECK_EN defined, a redirect whose target bits [1:0] are nonzero SHALL go to FAULT (or, from DRAIN, to FAULT on the ack), with if_fault=1, imem_req=0 and if_valid=0.
REQ-032 With STAGE_IF_MISALIGN_CHECK_EN defined, FAULT SHALL exit only on an aligned redirect, which clears if_fault and enters FETCH.
REQ-033 Without STAGE_IF_MISALIGN_CHECK_EN, redirect_pc[1:0] SHALL be forced to 0, the FAULT state SHALL not exist, and if_fault SHALL be tied 0.

Structure
REQ-034 Shared package riscv_pkg SHALL hold NOP_INSTR (32'h0000_0013), the fetch-state encoding and XLEN=32.
REQ-035 The skid buffer SHALL be sub-module if_skid_buf (one entry: data, pc, valid; load/drain/clear).

Verification
REQ-036 Reset release, zero-wait ack, RESET_PC=0: if_pc SHALL be 0, 4, 8 on consecutive cycles, and if_instr SHALL match memory.
REQ-037 Stall asserted on the cycle ack returns PC 8 and held 3 cycles: outputs SHALL hold PC 4, then show PC 8 without a refetch, and the next imem_addr SHALL be 12.
REQ-038 Ack delayed 3 cycles with redirect to 0x100 on the second waiting cycle: the old word SHALL be dropped, the next imem_addr SHALL be 0x100, and no if_valid SHALL occur for the old address.
REQ-039 Redirect and stall on the same cycle: if_valid SHALL be 0 on the next cycle and the skid buffer SHALL be cleared.
REQ-040 pc=32'hFFFF_FFFC fetch: the next imem_addr SHALL be 0.
REQ-041 With STAGE_IF_MISALIGN_CHECK_EN, redirect to 0x102: if_fault SHALL be 1 and imem_req 0 until a redirect to 0x200, then fetch SHALL resume at 0x200.
